// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
package serial_pkg;

  // Frame FSM states, 3-bit encoding shared with the receiver.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } serial_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/piso_serial_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and flags the last cycle of each period.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign tick = (cnt_q == LAST_TICK);

  // Next count: restart on state entry, wrap at the end of each bit period.
  always_comb begin
    cnt_d = cnt_q + TW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out frame transmitter: start bit, DATA_W bits LSB-first,
// optional even parity, STOP_BITS stop periods. All outputs are registered.
// Optional parity bit is enabled with macro PISO_SERIAL_TX_PARITY_EN.
module piso_serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  serial_state_e     state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, shreg_shift;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              line_q, line_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic              tick;
  logic              timer_clear;
`ifdef PISO_SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign accept      = tx_valid && ready_q;
  assign timer_clear = (state_d != state_q);
  assign shreg_shift = shreg_q >> 1;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  // Next state, shift register and the line value for the following cycle.
  // The line is registered, so each transition loads the value of the bit it enters.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    line_d    = line_q;
`ifdef PISO_SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        line_d = LINE_IDLE;
        if (accept) begin
          state_d   = ST_START;
          shreg_d   = tx_data;
          bit_cnt_d = '0;
          line_d    = LINE_START;
`ifdef PISO_SERIAL_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          line_d  = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef PISO_SERIAL_TX_PARITY_EN
            state_d   = ST_PARITY;
            line_d    = parity_q;
`else
            state_d   = ST_STOP;
            line_d    = LINE_IDLE;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            shreg_d   = shreg_shift;
            line_d    = shreg_shift[0];
          end
        end
      end
`ifdef PISO_SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          line_d  = LINE_IDLE;
        end
      end
`endif
      ST_STOP: begin
        line_d = LINE_IDLE;
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = LINE_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_STOP) && (state_d == ST_IDLE);
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      line_q    <= LINE_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PISO_SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      line_q    <= line_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PISO_SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_line  = line_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Testbench for piso_serial_tx: main instance (DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1)
// plus a CLKS_PER_BIT=1 instance. Expected line values come from the frame definition.
module tb_piso_serial_tx;

  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;
`ifdef PISO_SERIAL_TX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned NBITS  = 1 + DW + P + 1;
  localparam int unsigned PERIOD = NBITS * CPB + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tx_data, tx_data1;
  logic          tx_valid, tx_valid1;
  logic          tx_ready, tx_line, tx_busy, tx_done;
  logic          tx_ready1, tx_line1, tx_busy1, tx_done1;

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piso_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_line(tx_line), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  piso_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .tx_line(tx_line1), .tx_busy(tx_busy1), .tx_done(tx_done1)
  );

  // Reference: value of frame bit 'idx' (0 = start, then data LSB-first, parity, stop).
  function automatic logic exp_bit(input logic [DW-1:0] d, input int unsigned idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return d[idx-1];
    if (P == 1 && idx == DW + 1) return ^d;
    return 1'b1;
  endfunction

  // Sends one frame from an idle negedge and checks every cycle through tx_done.
  // Observed vector is {tx_line, tx_busy, tx_ready, tx_done}.
  task automatic send_frame(input logic [DW-1:0] d, input bit keep_valid, input bit disturb,
                            output int start_cyc);
    logic [3:0] exp_v;
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_cyc = cyc;
    if (!keep_valid) tx_valid = 1'b0;
    for (int unsigned k = 0; k < NBITS * CPB; k++) begin
      if (k > 0) @(negedge clk);
      exp_v = {exp_bit(d, k / CPB), 1'b1, 1'b0, 1'b0};
      tests_run++;
      if ({tx_line, tx_busy, tx_ready, tx_done} !== exp_v) begin
        fails++;
        $display("FAIL frame_cycle data=%h k=%0d got=%b exp=%b", d, k,
                 {tx_line, tx_busy, tx_ready, tx_done}, exp_v);
      end
      if (disturb) begin
        tx_data  = DW'($urandom);
        tx_valid = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    if (!keep_valid) tx_valid = 1'b0;
    tests_run++;
    if ({tx_line, tx_busy, tx_ready, tx_done} !== 4'b1011) begin
      fails++;
      $display("FAIL done_cycle data=%h got=%b exp=1011", d, {tx_line, tx_busy, tx_ready, tx_done});
    end
    if (!keep_valid) begin
      @(negedge clk);
      tests_run++;
      if ({tx_line, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
        fails++;
        $display("FAIL after_done data=%h got=%b exp=1010", d, {tx_line, tx_busy, tx_ready, tx_done});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({tx_line, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
        fails++;
        $display("FAIL reset_state got=%b exp=1010", {tx_line, tx_busy, tx_ready, tx_done});
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame();
    int s;
    send_frame(8'hA5, 1'b0, 1'b0, s);
`ifdef PISO_SERIAL_TX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b0, s);
`endif
    for (int i = 0; i < 5; i++) send_frame(DW'($urandom), 1'b0, 1'b0, s);
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    send_frame(8'h00, 1'b1, 1'b0, s1);
    send_frame(8'hFF, 1'b0, 1'b0, s2);
    tests_run++;
    if (s2 - s1 !== PERIOD) begin
      fails++;
      $display("FAIL b2b_period got=%0d exp=%0d", s2 - s1, PERIOD);
    end
  endtask

  task automatic test_busy_ignore();
    int s;
    for (int i = 0; i < 3; i++) send_frame(DW'($urandom), 1'b0, 1'b1, s);
  endtask

  task automatic test_reset_mid_frame();
    tx_data  = DW'($urandom);
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({tx_line, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
        fails++;
        $display("FAIL reset_mid_frame i=%0d got=%b exp=1010", i, {tx_line, tx_busy, tx_ready, tx_done});
      end
      // valid offered on the last reset edge must not be accepted
      if (i == 1) tx_valid = 1'b1;
    end
    rst      = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({tx_line, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
      fails++;
      $display("FAIL reset_priority got=%b exp=1010", {tx_line, tx_busy, tx_ready, tx_done});
    end
  endtask

  task automatic test_cpb1();
    logic [DW-1:0] d;
    logic [3:0]    exp_v;
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 8'h3C : DW'($urandom);
      tx_data1  = d;
      tx_valid1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_valid1 = 1'b0;
      for (int unsigned k = 0; k < NBITS; k++) begin
        if (k > 0) @(negedge clk);
        exp_v = {exp_bit(d, k), 1'b1, 1'b0, 1'b0};
        tests_run++;
        if ({tx_line1, tx_busy1, tx_ready1, tx_done1} !== exp_v) begin
          fails++;
          $display("FAIL cpb1_cycle data=%h k=%0d got=%b exp=%b", d, k,
                   {tx_line1, tx_busy1, tx_ready1, tx_done1}, exp_v);
        end
      end
      @(negedge clk);
      tests_run++;
      if ({tx_line1, tx_busy1, tx_ready1, tx_done1} !== 4'b1011) begin
        fails++;
        $display("FAIL cpb1_done data=%h got=%b exp=1011", d, {tx_line1, tx_busy1, tx_ready1, tx_done1});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst       = 1'b1;
    tx_data   = '0;
    tx_valid  = 1'b0;
    tx_data1  = '0;
    tx_valid1 = 1'b0;
    test_reset();
    test_frame();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_cpb1();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
